coeff_bank_swap: RTL

- Downstream of the SPI coefficient loader.
- On the loader's one-cycle "coefficients ready" pulse, it reads every coefficient out of the loader's read-only DPRAM port into a shadow register bank.
- It then swaps shadow and active banks on the next audio sample boundary, so the IIR biquad engine never sees a half-updated coefficient set.
- The engine reads coefficients from the active bank through a registered read port.

---
 rtl/coeff_bank_swap_pkg.sv | 19 +
 rtl/coeff_regbank.sv | 51 +++++
 rtl/coeff_bank_swap.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/coeff_bank_swap_pkg.sv
// Shared widths and FSM encodings for the coefficient bank-swap block.
package coeff_bank_swap_pkg;

   localparam int c_COEFF_NBITS = 40;
   localparam int c_NUM_COEFFS  = 32;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_FETCH = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;
   localparam logic [1:0] c_ST_PEND  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = c_ST_IDLE,
      ST_FETCH = c_ST_FETCH,
      ST_DRAIN = c_ST_DRAIN,
      ST_PEND  = c_ST_PEND
   } state_t;

endpackage

// File: rtl/coeff_regbank.sv
// Single coefficient register bank: one synchronous write port, one
// registered read port (out-of-range addresses read as zero), async clear.
module coeff_regbank
   import coeff_bank_swap_pkg::*;
#(
   parameter int COEFF_NBITS = c_COEFF_NBITS,
   parameter int NUM_COEFFS  = c_NUM_COEFFS,
   parameter int ADDR_NBITS  = 5
) (
   input  logic                   i_clk_sys,
   input  logic                   i_rstn,
   input  logic                   i_we,
   input  logic [ADDR_NBITS-1:0]  i_waddr,
   input  logic [COEFF_NBITS-1:0] i_wdata,
   input  logic [ADDR_NBITS-1:0]  i_raddr,
   output logic [COEFF_NBITS-1:0] o_rdata
);

   logic [COEFF_NBITS-1:0] mem_q [NUM_COEFFS];
   logic [COEFF_NBITS-1:0] mem_d [NUM_COEFFS];
   logic [COEFF_NBITS-1:0] rdata_q;
   logic [COEFF_NBITS-1:0] rdata_d;

   // Next-state of the storage array and the read register.
   always_comb begin
      mem_d   = mem_q;
      rdata_d = '0;
      if (i_we && (32'(i_waddr) < NUM_COEFFS)) begin
         mem_d[i_waddr] = i_wdata;
      end
      if (32'(i_raddr) < NUM_COEFFS) begin
         rdata_d = mem_q[i_raddr];
      end
   end

   // Storage and read register, cleared asynchronously.
   always_ff @(posedge i_clk_sys or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < NUM_COEFFS; i++) begin
            mem_q[i] <= '0;
         end
         rdata_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rdata_q <= rdata_d;
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/coeff_bank_swap.sv
// Double-buffered coefficient store: copies a freshly loaded set out of the
// loader DPRAM into the shadow bank, then swaps banks on a sample boundary.
//
//   state | meaning
//   IDLE  | waiting for a load request
//   FETCH | issuing DPRAM addresses 0..NUM_COEFFS-1, writing word counter-1
//   DRAIN | writing the last returned word into the shadow bank
//   PEND  | shadow complete, waiting for the sample boundary to swap
module coeff_bank_swap
   import coeff_bank_swap_pkg::*;
#(
   parameter int COEFF_NBITS = c_COEFF_NBITS,
   parameter int NUM_COEFFS  = c_NUM_COEFFS,
   parameter int ADDR_NBITS  = 5
) (
   input  logic                   i_clk_sys,
   input  logic                   i_rstn,
   input  logic                   i_coeffs_rdy,
   output logic [ADDR_NBITS-1:0]  o_coeff_addr,
   input  logic [COEFF_NBITS-1:0] i_coeff_data,
   input  logic                   i_sample_sync,
   input  logic [ADDR_NBITS-1:0]  i_eng_addr,
   output logic [COEFF_NBITS-1:0] o_eng_coeff,
   output logic                   o_busy,
   output logic                   o_bank_sel,
   output logic                   o_swap_done,
   output logic                   o_coeffs_valid
);

   localparam int CNT_NBITS = ADDR_NBITS + 1;
   localparam logic [CNT_NBITS-1:0]  CNT_ONE   = CNT_NBITS'(1);
   localparam logic [CNT_NBITS-1:0]  CNT_LAST  = CNT_NBITS'(NUM_COEFFS - 1);
   localparam logic [ADDR_NBITS-1:0] ADDR_LAST = ADDR_NBITS'(NUM_COEFFS - 1);

   state_t                 state_q, state_d;
   logic [CNT_NBITS-1:0]   cnt_q, cnt_d;
   logic                   req_q, req_d;
   logic                   bank_sel_q, bank_sel_d;
   logic                   valid_q, valid_d;
   logic                   rd_sel_q, rd_sel_d;
   logic                   swap_done;
   logic                   wr_en;
   logic [ADDR_NBITS-1:0]  wr_addr;
   logic [COEFF_NBITS-1:0] rdata0, rdata1;

   // Sequencing: fetch, drain, wait for the sample boundary, swap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      bank_sel_d = bank_sel_q;
      valid_d    = valid_q;
      swap_done  = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      case (state_q)
         ST_IDLE: begin
            if (i_coeffs_rdy || req_q) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (cnt_q != '0) begin
               wr_en   = 1'b1;
               wr_addr = ADDR_NBITS'(cnt_q - CNT_ONE);
            end
            if (i_coeffs_rdy) begin
               req_d = 1'b1;
            end
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            wr_en   = 1'b1;
            wr_addr = ADDR_LAST;
            if (i_coeffs_rdy) begin
               req_d = 1'b1;
            end
            state_d = ST_PEND;
         end
         ST_PEND: begin
            if (i_sample_sync) begin
               swap_done  = 1'b1;
               bank_sel_d = ~bank_sel_q;
               valid_d    = 1'b1;
               if (i_coeffs_rdy || req_q) begin
                  req_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (i_coeffs_rdy) begin
               // Newer set supersedes the pending one; refill the same shadow.
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Output mux follows the bank that was active when the read registered.
      rd_sel_d = bank_sel_q;
   end

   // Control registers.
   always_ff @(posedge i_clk_sys or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         bank_sel_q <= 1'b0;
         valid_q    <= 1'b0;
         rd_sel_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         bank_sel_q <= bank_sel_d;
         valid_q    <= valid_d;
         rd_sel_q   <= rd_sel_d;
      end
   end

   coeff_regbank #(
      .COEFF_NBITS (COEFF_NBITS),
      .NUM_COEFFS  (NUM_COEFFS),
      .ADDR_NBITS  (ADDR_NBITS)
   ) u_bank0 (
      .i_clk_sys (i_clk_sys),
      .i_rstn    (i_rstn),
      .i_we      (wr_en && bank_sel_q),
      .i_waddr   (wr_addr),
      .i_wdata   (i_coeff_data),
      .i_raddr   (i_eng_addr),
      .o_rdata   (rdata0)
   );

   coeff_regbank #(
      .COEFF_NBITS (COEFF_NBITS),
      .NUM_COEFFS  (NUM_COEFFS),
      .ADDR_NBITS  (ADDR_NBITS)
   ) u_bank1 (
      .i_clk_sys (i_clk_sys),
      .i_rstn    (i_rstn),
      .i_we      (wr_en && !bank_sel_q),
      .i_waddr   (wr_addr),
      .i_wdata   (i_coeff_data),
      .i_raddr   (i_eng_addr),
      .o_rdata   (rdata1)
   );

   assign o_coeff_addr   = (state_q == ST_FETCH) ? cnt_q[ADDR_NBITS-1:0] : '0;
   assign o_eng_coeff    = rd_sel_q ? rdata1 : rdata0;
   assign o_busy         = (state_q != ST_IDLE) || req_q;
   assign o_bank_sel     = bank_sel_q;
   assign o_swap_done    = swap_done;
   assign o_coeffs_valid = valid_q;

endmodule
